// File: rtl/divseq_if.sv
// divseq_if: execute-stage bundle between the pipeline and the sequential
// divider.
//
// The master side (pipeline or testbench) drives the operands, the operation
// select and the start/flush controls. The slave side (the divider) returns
// the busy flag, the done pulse and the result.
//
// Signals:
//   StartE          begin a divide with the current operands
//   FlushE          abort any divide in progress
//   ForwardedSrcAE  dividend (XLEN bits)
//   ForwardedSrcBE  divisor (XLEN bits)
//   Funct3E         100 DIV, 101 DIVU, 110 REM, 111 REMU
//   BusyE           divider occupied; the hazard unit stalls on this
//   DoneM           one-cycle pulse when QuotRemM becomes valid
//   QuotRemM        quotient or remainder, held until the next accepted start
interface divseq_if #(
   parameter int XLEN = 32
);
   logic            StartE;
   logic            FlushE;
   logic [XLEN-1:0] ForwardedSrcAE;
   logic [XLEN-1:0] ForwardedSrcBE;
   logic [2:0]      Funct3E;
   logic            BusyE;
   logic            DoneM;
   logic [XLEN-1:0] QuotRemM;

   modport master (
      output StartE, FlushE, ForwardedSrcAE, ForwardedSrcBE, Funct3E,
      input  BusyE, DoneM, QuotRemM
   );

   modport slave (
      input  StartE, FlushE, ForwardedSrcAE, ForwardedSrcBE, Funct3E,
      output BusyE, DoneM, QuotRemM
   );
endinterface

// File: rtl/divseq.sv
// divseq: sequential radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
//
// The divider iterates one quotient bit per cycle on operand magnitudes and
// applies the RISC-V sign rules afterwards. Division by zero returns all ones
// (DIV/DIVU) or the unmodified dividend (REM/REMU). The signed overflow case
// -2^(XLEN-1) / -1 needs no special handling: the magnitude path gives
// 2^(XLEN-1) / 1 with no negate.
//
// Ports:
//   clk      clock; every state update happens on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      divseq_if slave modport (operands, controls, busy/done/result)
//
// Configuration macro:
//   DIV_ZERO_BYPASS_EN  when defined, a zero divisor found in PREP jumps
//                       straight to DONE. When undefined, the full iteration
//                       runs and FIXUP forces the divide-by-zero result.
module divseq #(
   parameter int XLEN = 32
) (
   input logic     clk,
   input logic     reset_n,
   divseq_if.slave bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} DivState;

   DivState         state_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] bMag_q;
   logic [XLEN-1:0] result_q;
   logic [XLEN:0]   rem_q;
   logic [CW-1:0]   cnt_q;
   logic            signed_q;
   logic            remSel_q;
   logic            negQuot_q;
   logic            negRem_q;
   logic            busy_q;
   logic            done_q;

   logic [XLEN-1:0] aMag_d;
   logic [XLEN-1:0] bMag_d;
   logic [XLEN-1:0] quotFix_d;
   logic [XLEN-1:0] remFix_d;
   logic [XLEN:0]   shift_d;
   logic [XLEN:0]   trial_d;
   logic            unusedBits;

   // Datapath helpers. The magnitude negation is XLEN bits wide, so
   // -2^(XLEN-1) maps to itself and is then read as unsigned 2^(XLEN-1).
   // The trial subtraction is XLEN+1 bits wide, so its top bit is a valid
   // sign: the partial remainder is always below 2*|B|.
   always_comb begin
      aMag_d    = (signed_q && a_q[XLEN-1]) ? -a_q : a_q;
      bMag_d    = (signed_q && b_q[XLEN-1]) ? -b_q : b_q;
      shift_d   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
      trial_d   = shift_d - {1'b0, bMag_q};
      quotFix_d = negQuot_q ? -quo_q : quo_q;
      remFix_d  = negRem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
   end

   // Funct3E[2] is always 1 for the four divide opcodes. The top remainder
   // bit is only needed as the carry of the trial subtraction.
   assign unusedBits = ^{bus.Funct3E[2], rem_q[XLEN]};

   // Controller and datapath registers. Flush wins over everything except
   // reset and returns to IDLE without touching the held result. BusyE and
   // DoneM are registered alongside the state, so they change only on a
   // clock edge or on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         quo_q     <= '0;
         bMag_q    <= '0;
         result_q  <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         signed_q  <= 1'b0;
         remSel_q  <= 1'b0;
         negQuot_q <= 1'b0;
         negRem_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else if (bus.FlushE) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.StartE) begin
                  a_q      <= bus.ForwardedSrcAE;
                  b_q      <= bus.ForwardedSrcBE;
                  signed_q <= ~bus.Funct3E[0];
                  remSel_q <= bus.Funct3E[1];
                  busy_q   <= 1'b1;
                  state_q  <= PREP;
               end else begin
                  state_q <= IDLE;
               end
            end
            PREP: begin
               quo_q     <= aMag_d;
               bMag_q    <= bMag_d;
               rem_q     <= '0;
               negQuot_q <= signed_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
               negRem_q  <= signed_q & a_q[XLEN-1];
               cnt_q     <= CW'(XLEN - 1);
`ifdef DIV_ZERO_BYPASS_EN
               if (b_q == '0) begin
                  result_q <= remSel_q ? a_q : '1;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  state_q <= ITER;
               end
`else
               state_q <= ITER;
`endif
            end
            ITER: begin
               if (!trial_d[XLEN]) begin
                  rem_q <= trial_d;
                  quo_q <= {quo_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_q <= shift_d;
                  quo_q <= {quo_q[XLEN-2:0], 1'b0};
               end
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_q <= FIXUP;
               end
            end
            FIXUP: begin
`ifdef DIV_ZERO_BYPASS_EN
               result_q <= remSel_q ? remFix_d : quotFix_d;
`else
               if (bMag_q == '0) begin
                  result_q <= remSel_q ? a_q : '1;
               end else begin
                  result_q <= remSel_q ? remFix_d : quotFix_d;
               end
`endif
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.BusyE    = busy_q;
   assign bus.DoneM    = done_q;
   assign bus.QuotRemM = result_q;
endmodule

// File: tb/tb_divseq.sv
// tb_divseq: directed scoreboard bench for the divseq divider (XLEN = 32).
// The driver pushes each expected result and completion cycle into a queue.
// A separate monitor pops an entry on every DoneM pulse and compares it.
module tb_divseq;
   localparam logic [2:0] OP_DIV  = 3'b100;
   localparam logic [2:0] OP_DIVU = 3'b101;
   localparam logic [2:0] OP_REM  = 3'b110;
   localparam logic [2:0] OP_REMU = 3'b111;
   localparam int         LAT     = 35;
`ifdef DIV_ZERO_BYPASS_EN
   localparam int         ZLAT    = 2;
`else
   localparam int         ZLAT    = 35;
`endif

   typedef struct {
      logic [31:0] val;
      int          cyc;
      string       name;
   } ExpEntry;

   logic clk;
   logic reset_n;
   int   cycleCnt;
   int   errors;
   int   checks;
   logic [31:0] lastResult;
   ExpEntry expQ[$];

   divseq_if #(.XLEN(32)) bus ();

   divseq #(.XLEN(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Free-running clock and cycle counter used to time each completion.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cycleCnt = 0;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // One comparison: count it, and report it when it does not match.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: every DoneM pulse must match the oldest outstanding expectation,
   // both in value and in the cycle it arrives.
   always @(negedge clk) begin
      ExpEntry e;
      if (reset_n && bus.DoneM) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput({e.name, "_value"}, bus.QuotRemM, e.val);
            checkOutput({e.name, "_cycle"}, 32'(cycleCnt), 32'(e.cyc));
         end
      end
   end

   // Issue one divide at the current negedge and wait for its DoneM. The
   // task returns at the negedge of the DONE cycle, so the next call starts
   // back-to-back. With poke set, StartE is raised with different operands
   // while busy; the divider must ignore it.
   task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expVal, input int lat, input string name,
                                input bit poke);
      ExpEntry e;
      int n;
      int busyCnt;
      bus.Funct3E        = f;
      bus.ForwardedSrcAE = a;
      bus.ForwardedSrcBE = b;
      bus.StartE         = 1'b1;
      @(negedge clk);
      bus.StartE = 1'b0;
      e.val  = expVal;
      e.cyc  = cycleCnt + lat - 1;
      e.name = name;
      expQ.push_back(e);
      n       = 0;
      busyCnt = 0;
      while (!bus.DoneM && n < 200) begin
         if (bus.BusyE) busyCnt++;
         if (poke && n == 4) begin
            bus.StartE         = 1'b1;
            bus.ForwardedSrcAE = 32'hDEAD_BEEF;
            bus.ForwardedSrcBE = 32'h0000_0003;
         end
         if (poke && n == 8) begin
            bus.StartE = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_done_seen"}, {31'd0, bus.DoneM}, 32'd1);
      checkOutput({name, "_busy_cycles"}, 32'(busyCnt), 32'(lat - 1));
      lastResult = expVal;
   endtask

   initial begin
      errors             = 0;
      checks             = 0;
      lastResult         = 32'd0;
      reset_n            = 1'b0;
      bus.StartE         = 1'b0;
      bus.FlushE         = 1'b0;
      bus.Funct3E        = OP_DIV;
      bus.ForwardedSrcAE = 32'd0;
      bus.ForwardedSrcBE = 32'd0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_busy", {31'd0, bus.BusyE}, 32'd0);
      checkOutput("reset_done", {31'd0, bus.DoneM}, 32'd0);
      checkOutput("reset_result", bus.QuotRemM, 32'd0);

      // Signed, unsigned, overflow and divide-by-zero vectors, back-to-back.
      applyStimulus(OP_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT,  "div_100_m7",   1'b0);
      applyStimulus(OP_REM,  32'd100,       32'hFFFF_FFF9, 32'h0000_0002, LAT,  "rem_100_m7",   1'b0);
      applyStimulus(OP_DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, LAT,  "div_m100_7",   1'b0);
      applyStimulus(OP_REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, LAT,  "rem_m100_7",   1'b0);
      applyStimulus(OP_DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, LAT,  "divu_max_16",  1'b0);
      applyStimulus(OP_REMU, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, LAT,  "remu_max_16",  1'b0);
      applyStimulus(OP_DIVU, 32'd100,       32'd7,         32'h0000_000E, LAT,  "divu_poke",    1'b1);
      applyStimulus(OP_REMU, 32'd100,       32'd7,         32'h0000_0002, LAT,  "remu_100_7",   1'b0);
      applyStimulus(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT,  "div_overflow", 1'b0);
      applyStimulus(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT,  "rem_overflow", 1'b0);
      applyStimulus(OP_DIV,  32'h1234_5678, 32'd0,         32'hFFFF_FFFF, ZLAT, "div_by_zero",  1'b0);
      applyStimulus(OP_REMU, 32'h1234_5678, 32'd0,         32'h1234_5678, ZLAT, "remu_by_zero", 1'b0);
      applyStimulus(OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, ZLAT, "divu_by_zero", 1'b0);
      applyStimulus(OP_REM,  32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, ZLAT, "rem_neg_zero", 1'b0);

      // Flush mid-ITER: no DoneM pulse, held result unchanged, then recovery.
      bus.Funct3E        = OP_DIVU;
      bus.ForwardedSrcAE = 32'd1000;
      bus.ForwardedSrcBE = 32'd3;
      bus.StartE         = 1'b1;
      @(negedge clk);
      bus.StartE = 1'b0;
      repeat (8) @(negedge clk);
      bus.FlushE = 1'b1;
      @(negedge clk);
      bus.FlushE = 1'b0;
      checkOutput("flush_busy", {31'd0, bus.BusyE}, 32'd0);
      checkOutput("flush_done", {31'd0, bus.DoneM}, 32'd0);
      checkOutput("flush_result_held", bus.QuotRemM, lastResult);
      repeat (45) @(negedge clk);
      applyStimulus(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, LAT, "after_flush", 1'b0);

      // Asynchronous reset mid-ITER clears the outputs without a clock edge.
      @(negedge clk);
      bus.Funct3E        = OP_DIV;
      bus.ForwardedSrcAE = 32'd777;
      bus.ForwardedSrcBE = 32'd5;
      bus.StartE         = 1'b1;
      @(negedge clk);
      bus.StartE = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_reset_busy", {31'd0, bus.BusyE}, 32'd0);
      checkOutput("async_reset_done", {31'd0, bus.DoneM}, 32'd0);
      checkOutput("async_reset_result", bus.QuotRemM, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      applyStimulus(OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LAT, "after_reset", 1'b0);

      repeat (3) @(negedge clk);
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global guard so the bench always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "[TB] timeout");
   end
endmodule

// File: doc/divseq.md
# divseq

Sequential radix-2 integer divider for the RISC-V M-extension DIV, DIVU, REM and REMU operations. It is the division counterpart of the pipelined multiplier in the MDU. It accepts operands from the execute-stage forwarding muxes and iterates one quotient bit per cycle on operand magnitudes. It applies the RISC-V sign and special-case rules and holds the result until the next operation starts. The hazard unit stalls the pipeline while `BusyE` is high.

## Interface
- `XLEN`, default 32: operand and result width (32 or 64).
- `clk`  input  1: clock; all state updates on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `StartE`  input  1: begin a divide with the current operands; sampled only when not busy.
- `FlushE`  input  1: abort any operation in progress.
- `ForwardedSrcAE`  input  XLEN: dividend.
- `ForwardedSrcBE`  input  XLEN: divisor.
- `Funct3E`  input  3: operation select. 100 = DIV, 101 = DIVU, 110 = REM, 111 = REMU.
- `BusyE`  output  1: high in states PREP, ITER and FIXUP.
- `DoneM`  output  1: one-cycle pulse when `QuotRemM` becomes valid.
- `QuotRemM`  output  XLEN: quotient (DIV/DIVU) or remainder (REM/REMU). Held until the next accepted start.

## Operation
- States: IDLE, PREP, ITER, FIXUP, DONE. Reset forces IDLE, `BusyE` = 0, `DoneM` = 0, `QuotRemM` = 0, counter = 0.
- IDLE or DONE with `StartE` = 1 and `FlushE` = 0:
  - Capture A, B and `Funct3E`.
  - Signed = ~`Funct3E`[0].
  - Go to PREP.
- `StartE` while `BusyE` is high is ignored.
- PREP:
  - Compute |A| and |B|. Signed mode takes the two's-complement magnitude; unsigned passes the value through.
  - Record NegQ = signed & (A[XLEN-1] ^ B[XLEN-1]) and NegR = signed & A[XLEN-1].
  - Clear the partial remainder to 0 and load the counter with XLEN-1.
  - If B = 0, go to DONE via the bypass when `DIV_ZERO_BYPASS_EN` is defined. Otherwise go to ITER.
- ITER, each cycle:
  - Shift {R, Q} left one bit, shifting the next dividend MSB into R.
  - Trial subtract R − |B| at XLEN+1 bits.
  - If the result is non-negative, commit it and set the Q LSB to 1. Otherwise restore and set the Q LSB to 0.
  - Decrement the counter. After the iteration with counter = 0, go to FIXUP.
- FIXUP:
  - Quotient = NegQ ? −Q : Q. Remainder = NegR ? −R : R.
  - Select the quotient or remainder by `Funct3E`[1], register it into `QuotRemM`, and go to DONE.
- DONE:
  - `DoneM` = 1 for this cycle only.
  - Go to IDLE, or to PREP if a new start is accepted in the same cycle.
- Divide by zero: quotient = all ones for both signed and unsigned; remainder = dividend unmodified.
- Signed overflow (A = −2^(XLEN-1), B = −1):
  - Quotient = −2^(XLEN-1), remainder = 0.
  - This falls out of the magnitude path: 2^(XLEN-1) / 1, no negate, truncated. No special logic is needed.
- Arithmetic widths:
  - The partial remainder is XLEN+1 bits wide.
  - Magnitude negation is XLEN bits. −2^(XLEN-1) maps to itself, read as unsigned 2^(XLEN-1).
- `FlushE` = 1 in any state:
  - Next state is IDLE with no `DoneM` pulse. `QuotRemM` keeps its previous value.
  - Flush takes priority over a simultaneous `StartE`.
- `reset_n` deasserted mid-operation: immediate return to the reset state with no `DoneM`.

## Timing
- Start sampled at edge 0 (cycle 0). PREP is cycle 1. ITER is cycles 2 through XLEN+1. FIXUP is cycle XLEN+2. DONE (`DoneM` high, `QuotRemM` valid) is cycle XLEN+3.
- `BusyE` is high in cycles 1 through XLEN+2.
- Divide by zero with the bypass enabled: DONE in cycle 2, `BusyE` high only in cycle 1.
- Back-to-back: a start accepted in a DONE cycle puts the block in PREP in the next cycle. Throughput is one operation per XLEN+3 cycles.

## Configuration
- `DIV_ZERO_BYPASS_EN` defined:
  - B = 0 detected in PREP jumps directly to DONE.
  - The result register is loaded in PREP with all ones (DIV/DIVU) or A (REM/REMU).
- Not defined:
  - Divide by zero runs the full iteration with uniform latency XLEN+3.
  - FIXUP forces the same all-ones / A result, ignoring NegQ and NegR.

## Test plan
- XLEN = 32, DIV 100 / −7: `DoneM` pulses in cycle 35, `QuotRemM` = 0xFFFFFFF2 (−14). REM on the same operands gives 0x00000002.
- DIVU 0xFFFFFFFF / 0x00000010 gives 0x0FFFFFFF. REMU gives 0x0000000F. `BusyE` high for exactly 34 cycles.
- DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000. REM gives 0.
- DIV 0x12345678 / 0 gives 0xFFFFFFFF. REMU 0x12345678 / 0 gives 0x12345678.
  - With the bypass: `DoneM` in cycle 2.
  - Without the bypass: `DoneM` in cycle 35.
- `FlushE` asserted in cycle 10 of a DIVU: next cycle IDLE, `BusyE` = 0, no `DoneM`, `QuotRemM` unchanged. A start in the following cycle completes normally.
- `reset_n` pulsed low mid-ITER: `BusyE`, `DoneM` and `QuotRemM` go to 0 asynchronously. `StartE` held while busy is confirmed ignored.
